// File: rtl/snap_playback_reader.sv
// Purpose: reads a snapshot/playback BRAM in address order and streams the words out, one-shot or looped.
// Latency: start to first m_valid is 3 cycles; sustains 1 word/cycle while m_ready stays high.
// Backpressure: at most 2 reads run ahead of the consumer, held in a 2-entry skid FIFO; stalls hold m_data.
module snap_playback_reader #(
    parameter int DWIDTH  = 128,
    parameter int AWIDTH  = 10,
    parameter int LCWIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [AWIDTH:0]    length,
    input  logic               loop_en,
    output logic               bram_en_a,
    output logic               bram_we,
    output logic [AWIDTH-1:0]  bram_addr,
    output logic [DWIDTH-1:0]  bram_wr_data,
    input  logic [DWIDTH-1:0]  bram_rd_data,
    output logic [DWIDTH-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic               done,
    output logic [LCWIDTH-1:0] loop_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AWIDTH:0]      len_q, len_d;
    logic                 loop_q, loop_d;
    logic [AWIDTH-1:0]    addr_q, addr_d;
    logic [AWIDTH:0]      issued_q, issued_d;
    logic [LCWIDTH-1:0]   lc_q, lc_d;
    logic                 done_q, done_d;

    // Skid FIFO: head_q always drives m_data; tail_q only fills while the head is stalled.
    logic                 inflight_q, inflight_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [DWIDTH-1:0]    head_q, head_d;
    logic [DWIDTH-1:0]    tail_q, tail_d;

    logic                 pop;
    logic [1:0]           occ_nxt;
    logic                 issue;

    // Occupancy after this edge (FIFO plus returning read, minus the word leaving); gates read issue.
    always_comb begin
        pop     = (cnt_q != 2'd0) & m_ready;
        occ_nxt = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        issue   = (state_q == ST_RUN) & ~stop & (occ_nxt < 2'd2);
    end

    // Playback control: length/loop capture, address walk, pass counting and termination.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        loop_d   = loop_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        lc_d     = lc_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start landing on the done cycle belongs to the run that just ended.
                if (start && !done_q) begin
                    len_d    = (length == '0) ? {1'b1, {AWIDTH{1'b0}}} : length;
                    loop_d   = loop_en;
                    addr_d   = '0;
                    issued_d = '0;
                    lc_d     = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if ((issued_q + 1'b1) == len_q) begin
                        lc_d = lc_q + 1'b1;
                        if (loop_q) begin
                            addr_d   = '0;
                            issued_d = '0;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // No reads are issued here, so occ_nxt == 0 means the final word is leaving now.
                if (occ_nxt == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Skid FIFO update: capture every returning read, shift tail to head on a pop.
    always_comb begin
        inflight_d = issue;
        cnt_d      = occ_nxt;
        head_d     = head_q;
        tail_d     = tail_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = bram_rd_data;
                else               tail_d = bram_rd_data;
            end
            2'b01: head_d = tail_q;
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = bram_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = bram_rd_data;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            loop_q     <= 1'b0;
            addr_q     <= '0;
            issued_q   <= '0;
            lc_q       <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            lc_q       <= lc_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // The fabric port is read-only from this side.
    always_comb begin
        bram_en_a    = issue;
        bram_we      = 1'b0;
        bram_addr    = addr_q;
        bram_wr_data = '0;
        m_data       = head_q;
        m_valid      = (cnt_q != 2'd0);
        busy         = (state_q != ST_IDLE);
        done         = done_q;
        loop_count   = lc_q;
    end

endmodule

// File: tb/tb_snap_playback_reader.sv
// Purpose: bench for snap_playback_reader with a behavioural BRAM and a stream scoreboard.
// Latency: checks the 3-cycle start-to-valid timing and done/busy placement cycle by cycle.
// Backpressure: drives toggled and random m_ready and checks ordering, stall stability and read-ahead.
module tb_snap_playback_reader;
    localparam int DW    = 128;
    localparam int AW    = 10;
    localparam int LCW   = 16;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rst_n, start, stop, loop_en, m_ready;
    logic [AW:0]    length;
    logic           bram_en_a, bram_we, m_valid, busy, done;
    logic [AW-1:0]  bram_addr;
    logic [DW-1:0]  bram_wr_data, m_data;
    logic [DW-1:0]  bram_rd_data = '0;
    logic [LCW-1:0] loop_count;

    logic [DW-1:0]  mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Scoreboard state filled by the monitor.
    logic [DW-1:0] rx[$];
    int            iaddr[$];
    int            iss_cnt = 0, xf_cnt = 0, max_ahead = 0, done_cnt = 0, stab_viol = 0;

    snap_playback_reader #(.DWIDTH(DW), .AWIDTH(AW), .LCWIDTH(LCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .length(length),
        .loop_en(loop_en), .bram_en_a(bram_en_a), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .done(done), .loop_count(loop_count)
    );

    always #5 clk = ~clk;

    // Unregistered BRAM primitive: data appears the cycle after the enable.
    always @(posedge clk) if (bram_en_a) bram_rd_data <= mem[bram_addr];

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_dat;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                iss_cnt    = xf_cnt;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!m_valid || m_data !== prev_dat)) stab_viol++;
                if (bram_en_a) begin iss_cnt++; iaddr.push_back(int'(bram_addr)); end
                if (m_valid && m_ready) begin xf_cnt++; rx.push_back(m_data); end
                if (done) done_cnt++;
                if (iss_cnt - xf_cnt > max_ahead) max_ahead = iss_cnt - xf_cnt;
                prev_stall = m_valid && !m_ready;
                prev_dat   = m_data;
            end
        end
    end

    task automatic fill_mem(input bit random_data);
        for (int i = 0; i < DEPTH; i++)
            mem[i] = random_data ? {$urandom, $urandom, $urandom, $urandom} : DW'(i);
    endtask

    task automatic start_run(input int len, input bit lp);
        @(posedge clk); #1;
        start = 1'b1; length = (AW+1)'(len); loop_en = lp;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready held high, 1: toggled 1010..., 2: random.
    task automatic run_until_done(input int base_done, input int budget, input int mode, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget) begin
            @(posedge clk); #1;
            if (done_cnt > base_done) begin ok = 1'b1; break; end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 2) == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, busy, done, bram_en_a, bram_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got %b want 00000", {m_valid, busy, done, bram_en_a, bram_we});
        end
        checks++;
        if (m_data !== '0 || bram_wr_data !== '0 || bram_addr !== '0 || loop_count !== '0) begin
            errors++; $display("FAIL reset_data m_data=%h addr=%0d lc=%0d want all 0", m_data, bram_addr, loop_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({m_valid, busy, bram_en_a} !== 3'b0) begin
            errors++; $display("FAIL reset_release got %b want 000", {m_valid, busy, bram_en_a});
        end
    endtask

    task automatic test_basic();
        logic [3:0] got_ctl, exp_ctl;
        @(posedge clk); #1;
        start = 1'b1; length = (AW+1)'(4); loop_en = 1'b0; m_ready = 1'b1; stop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            got_ctl = {m_valid, done, busy, bram_en_a};
            exp_ctl = {(c >= 3 && c <= 6), (c == 7), (c >= 1 && c <= 6), (c >= 1 && c <= 4)};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++; $display("FAIL basic_ctl cycle %0d {valid,done,busy,en} got %b want %b", c, got_ctl, exp_ctl);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (bram_addr !== AW'(c - 1)) begin
                    errors++; $display("FAIL basic_addr cycle %0d got %0d want %0d", c, bram_addr, c - 1);
                end
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (m_data !== mem[c - 3]) begin
                    errors++; $display("FAIL basic_data cycle %0d got %h want %h", c, m_data, mem[c - 3]);
                end
            end
            if (c == 7) begin
                checks++;
                if (loop_count !== LCW'(1)) begin
                    errors++; $display("FAIL basic_loop_count got %0d want 1", loop_count);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 4; r++) begin
            int n, base, bd, bad, mode;
            bit ok;
            if (r == 0) begin
                n = 8; mode = 1;
            end else begin
                fill_mem(1'b1);
                n = (r == 3) ? 1 : int'($urandom_range(2, 24));
                mode = 2;
            end
            base = rx.size();
            bd   = done_cnt;
            m_ready = 1'b1;
            start_run(n, 1'b0);
            run_until_done(bd, 400, mode, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL bp_timeout run %0d len %0d no done", r, n); end
            checks++;
            if (rx.size() - base !== n) begin
                errors++; $display("FAIL bp_count run %0d got %0d words want %0d", r, rx.size() - base, n);
            end
            bad = 0;
            for (int k = 0; k < n && base + k < rx.size(); k++)
                if (rx[base + k] !== mem[k]) bad++;
            checks++;
            if (bad !== 0) begin errors++; $display("FAIL bp_data run %0d got %0d wrong words want 0", r, bad); end
            checks++;
            if (loop_count !== LCW'(1) || busy !== 1'b0) begin
                errors++; $display("FAIL bp_end run %0d lc=%0d busy=%b want lc=1 busy=0", r, loop_count, busy);
            end
        end
        checks++;
        if (stab_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stab_viol); end
        checks++;
        if (max_ahead > 2) begin errors++; $display("FAIL bp_read_ahead got %0d want <=2", max_ahead); end
    endtask

    task automatic test_loop();
        int base, bd, n, cyc, bubbles, extra, total, bad;
        bit seen, ok;
        logic [LCW-1:0] lc9, lc12;
        base = rx.size(); bd = done_cnt; n = 0; cyc = 0; bubbles = 0; seen = 1'b0;
        lc9 = '0; lc12 = '0;
        @(posedge clk); #1;
        start = 1'b1; length = (AW+1)'(3); loop_en = 1'b1; m_ready = 1'b1; stop = 1'b0;
        while (n < 12 && cyc < 100) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
            else if (seen) bubbles++;
            if (m_valid && m_ready) begin
                n++;
                if (n == 9)  lc9  = loop_count;
                if (n == 12) lc12 = loop_count;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        run_until_done(bd, 50, 0, ok);
        total = rx.size() - base;
        extra = total - 12;
        checks++;
        if (n !== 12 || !ok) begin errors++; $display("FAIL loop_progress got %0d transfers done=%0d want 12 and done", n, ok); end
        checks++;
        if (bubbles !== 0) begin errors++; $display("FAIL loop_bubble got %0d idle cycles want 0", bubbles); end
        checks++;
        if (lc9 !== LCW'(3) || lc12 !== LCW'(4)) begin
            errors++; $display("FAIL loop_count_pass got %0d/%0d want 3/4", lc9, lc12);
        end
        checks++;
        if (extra < 0 || extra > 2) begin errors++; $display("FAIL loop_stop_extra got %0d extra words want 0..2", extra); end
        bad = 0;
        for (int k = 0; k < total; k++)
            if (rx[base + k] !== mem[k % 3]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL loop_data got %0d wrong words want 0", bad); end
        checks++;
        if (loop_count !== LCW'(total / 3)) begin
            errors++; $display("FAIL loop_count_stop got %0d want %0d", loop_count, total / 3);
        end
    endtask

    task automatic test_full_depth();
        int base, bi, bd, bad_d, bad_a;
        bit ok;
        base = rx.size(); bi = iaddr.size(); bd = done_cnt;
        m_ready = 1'b1;
        start_run(0, 1'b0);
        checks++;
        if (loop_count !== '0) begin errors++; $display("FAIL full_lc_clear got %0d want 0", loop_count); end
        run_until_done(bd, 1300, 0, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || rx.size() - base !== DEPTH || iaddr.size() - bi !== DEPTH) begin
            errors++; $display("FAIL full_count got %0d words %0d reads done=%0d want %0d", rx.size() - base, iaddr.size() - bi, ok, DEPTH);
        end
        bad_d = 0; bad_a = 0;
        for (int k = 0; k < DEPTH && base + k < rx.size(); k++)
            if (rx[base + k] !== mem[k]) bad_d++;
        for (int k = 0; k < DEPTH && bi + k < iaddr.size(); k++)
            if (iaddr[bi + k] !== k) bad_a++;
        checks++;
        if (bad_d !== 0 || bad_a !== 0) begin
            errors++; $display("FAIL full_order got %0d bad data %0d bad addrs want 0/0", bad_d, bad_a);
        end
        checks++;
        if (done_cnt - bd !== 1 || loop_count !== LCW'(1) || bram_addr !== '0) begin
            errors++; $display("FAIL full_end done=%0d lc=%0d addr=%0d want 1/1/0", done_cnt - bd, loop_count, bram_addr);
        end
    endtask

    task automatic test_ignored_start();
        int base, bd, iss0, cyc, busy_seen, bad;
        bit hit;
        base = rx.size(); bd = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; length = (AW+1)'(5); loop_en = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1; length = (AW+1)'(2); loop_en = 1'b1;
        @(posedge clk); #1; length = (AW+1)'(9);
        @(posedge clk); #1; start = 1'b0;
        hit = 1'b0; cyc = 0;
        while (!hit && cyc < 50) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                hit = 1'b1;
                start = 1'b1; length = (AW+1)'(3); loop_en = 1'b0;
            end
            cyc++;
        end
        iss0 = iss_cnt;
        checks++;
        if (!hit || rx.size() - base !== 5) begin
            errors++; $display("FAIL ign_run got %0d words done_seen=%0d want 5 and done", rx.size() - base, hit);
        end
        busy_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0 || iss_cnt !== iss0) begin
            errors++; $display("FAIL ign_start_on_done busy=%0d new reads=%0d want 0/0", busy_seen, iss_cnt - iss0);
        end
        bad = 0;
        for (int k = 0; k < 5 && base + k < rx.size(); k++)
            if (rx[base + k] !== mem[k]) bad++;
        checks++;
        if (bad !== 0 || done_cnt - bd !== 1 || loop_count !== LCW'(1)) begin
            errors++; $display("FAIL ign_seq bad=%0d dones=%0d lc=%0d want 0/1/1", bad, done_cnt - bd, loop_count);
        end
    endtask

    task automatic test_reset_mid();
        int base, bd;
        bit ok;
        m_ready = 1'b0;
        start_run(8, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || bram_en_a !== 1'b0) begin
            errors++; $display("FAIL rst_pre valid=%b busy=%b en=%b want 1/1/0", m_valid, busy, bram_en_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, busy, done, bram_en_a} !== 4'b0 || m_data !== '0 || loop_count !== '0 || bram_addr !== '0) begin
            errors++; $display("FAIL rst_async ctl=%b data=%h lc=%0d addr=%0d want all 0",
                               {m_valid, busy, done, bram_en_a}, m_data, loop_count, bram_addr);
        end
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = rx.size(); bd = done_cnt;
        m_ready = 1'b1;
        start_run(2, 1'b0);
        run_until_done(bd, 50, 0, ok);
        checks++;
        if (!ok || rx.size() - base !== 2) begin
            errors++; $display("FAIL rst_replay_count got %0d words done=%0d want 2", rx.size() - base, ok);
        end else begin
            checks++;
            if (rx[base] !== mem[0] || rx[base + 1] !== mem[1]) begin
                errors++; $display("FAIL rst_replay_data got %h,%h want %h,%h", rx[base], rx[base + 1], mem[0], mem[1]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; length = '0; loop_en = 1'b0; m_ready = 1'b0;
        fill_mem(1'b0);
        test_reset();
        test_basic();
        test_backpressure();
        test_loop();
        test_full_depth();
        test_ignored_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snap_playback_reader.md
Name: snap_playback_reader

Overview:
- Fabric-side reader of a dual-port snapshot/playback BRAM.
- Software fills the BRAM through the 32-bit bus port; this block drives the 128-bit fabric port and reads the words back in address order.
- Output is a valid/ready stream, supporting one-shot or looped playback.
- Used for DAC test waveforms and loopback checks of the snapshot capture path.

Parameters:
- DWIDTH, 128, fabric-port data width in bits.
- AWIDTH, 10, fabric-port address width; depth = 2**AWIDTH words.
- LCWIDTH, 16, width of the loop counter.

Ports:
- clk  in  1  Single clock for all logic and the BRAM fabric port.
- rst_n  in  1  Reset, asynchronous, active-low.
- start  in  1  Single-cycle pulse that begins playback; ignored while busy=1.
- stop  in  1  Single-cycle pulse that ends read issue; data already in flight still drains.
- length  in  AWIDTH+1  Word count, sampled at start; 0 is treated as 2**AWIDTH.
- loop_en  in  1  Sampled at start; 1 restarts at address 0 after the last word.
- bram_en_a  out  1  Read enable to the BRAM fabric port.
- bram_we  out  1  Write enable to the BRAM fabric port; constant 0.
- bram_addr  out  AWIDTH  Read address.
- bram_wr_data  out  DWIDTH  Write data; constant 0.
- bram_rd_data  in  DWIDTH  Read data; valid exactly 1 cycle after bram_en_a (unregistered primitive).
- m_data  out  DWIDTH  Stream data.
- m_valid  out  1  Stream valid.
- m_ready  in  1  Stream ready.
- busy  out  1  High in RUN or DRAIN.
- done  out  1  One-cycle pulse when playback finishes.
- loop_count  out  LCWIDTH  Number of completed passes in the current run; wraps at 2**LCWIDTH.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. Skid FIFO empty. In-flight flag cleared.
- Skid FIFO, depth 2, holds returned read data. m_data/m_valid come from the FIFO head register, which is a register, not bram_rd_data.
- Handshake:
  - Transfer occurs when m_valid & m_ready.
  - m_data stays stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer, except on reset.
- Read issue condition: state=RUN & (fifo_count + inflight - (m_valid & m_ready)) < 2.
  - Bursts sustain 1 word/cycle with m_ready held high.
  - No FIFO overflow under any m_ready pattern.
- Every issued read is captured into the FIFO on the following edge. No read is ever discarded, except on reset.
- States:
  - IDLE: on start, latch len_q (0 becomes 2**AWIDTH) and loop_q; set addr=0, issued=0; go to RUN.
  - RUN: on each issued read, addr and issued increment.
    - If issued reaches len_q and loop_q=1: addr=0, issued=0, loop_count+1, stay in RUN.
    - If issued reaches len_q and loop_q=0: loop_count+1, go to DRAIN.
  - RUN + stop: stop issuing from that cycle (a read gated by the same cycle is not issued); go to DRAIN; loop_count is not incremented.
  - DRAIN: when FIFO is empty and no read is in flight, pulse done for 1 cycle and go to IDLE.
- Timing with the start pulse sampled in cycle 0:
  - Cycle 1: RUN, bram_en_a=1, addr=0.
  - Cycle 2: rd_data valid.
  - Cycle 3: m_valid=1. Start-to-first-valid latency is 3 cycles.
- done asserts in the cycle after the final transfer, when the final transfer empties the FIFO. busy falls in that same cycle.
- loop_count clears on start.
- A start arriving together with done, or while busy, is ignored.
- stop in IDLE or DRAIN has no effect. Simultaneous start and stop in IDLE: start wins, stop is ignored.
- Address wrap: with len=2**AWIDTH, addr goes 1023→0 without a glitch.

Test Plan:
- BRAM word n = n. Then start, length=4, loop_en=0, m_ready=1 → m_valid in cycles 3–6, data 0,1,2,3, done in cycle 7, loop_count=1, busy=0 from cycle 7.
- length=8, m_ready toggled 1010… → data 0..7 delivered in order with no drops or duplicates, m_data stable while stalled, at most 2 reads ahead of consumption.
- length=3, loop_en=1, m_ready=1 for 12 transfers → 0,1,2 repeated 4 times back-to-back with no bubble at the wrap, loop_count=4 (3 after the 3rd pass); then stop → at most 2 extra words, then done.
- length=0, m_ready=1 → 1024 words 0..1023 with addr wrapping to 0 once, single done, loop_count=1.
- start pulses during RUN plus one start coincident with done → ignored, sequence unchanged.
- rst_n low during RUN with FIFO full and m_ready=0 → all outputs 0 immediately. A later start with length=2 replays 0,1 cleanly.
